// File: rtl/piso_ctrl_pkg.sv
// Shared definitions for the parallel-in / serial-out transmitter:
// FSM state encoding and the counter-width helper.
package piso_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } piso_state_t;

   // Bits needed to count 0..range-1, never fewer than one.
   function automatic int cnt_width(input int range);
      if (range <= 1) begin
         return 1;
      end else begin
         return $clog2(range);
      end
   endfunction

endpackage

// File: rtl/piso_shreg.sv
// Loadable shift register; head is the bit currently presented on the line,
// taken from the MSB or LSB end depending on MSB_FIRST.
module piso_shreg #(
   parameter int N         = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         shift_en,
   input  logic [N-1:0] d,
   output logic         head
);

   logic [N-1:0] r_data;

   // Data register: load has priority over shifting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= {N{1'b0}};
      end else if (load) begin
         r_data <= d;
      end else if (shift_en) begin
         if (MSB_FIRST) begin
            r_data <= {r_data[N-2:0], 1'b0};
         end else begin
            r_data <= {1'b0, r_data[N-1:1]};
         end
      end else begin
         r_data <= r_data;
      end
   end

   assign head = MSB_FIRST ? r_data[N-1] : r_data[0];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Serialising transmitter: FSM plus bit/divide counters driving piso_shreg.
// Each bit is held DIV cycles; one DONE cycle closes every completed frame.
module piso_tx_ctrl
   import piso_ctrl_pkg::*;
#(
   parameter int   N         = 8,
   parameter int   DIV       = 4,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_LVL  = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] parallel_in,
   input  logic         abort,
   output logic         serial_out,
   output logic         frame,
   output logic         busy,
   output logic         done
);

   localparam int DIV_W = cnt_width(DIV);
   localparam int BIT_W = cnt_width(N);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);

   piso_state_t      r_state;
   piso_state_t      w_state_nxt;
   logic [DIV_W-1:0] r_div_cnt;
   logic [DIV_W-1:0] w_div_nxt;
   logic [BIT_W-1:0] r_bit_cnt;
   logic [BIT_W-1:0] w_bit_nxt;
   logic             w_load;
   logic             w_shift;
   logic             w_head;

   piso_shreg #(
      .N         (N),
      .MSB_FIRST (MSB_FIRST)
   ) u_shreg (
      .clk      (clk),
      .rst_n    (reset),
      .load     (w_load),
      .shift_en (w_shift),
      .d        (parallel_in),
      .head     (w_head)
   );

   // State and counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_div_cnt <= {DIV_W{1'b0}};
         r_bit_cnt <= {BIT_W{1'b0}};
      end else begin
         r_state   <= w_state_nxt;
         r_div_cnt <= w_div_nxt;
         r_bit_cnt <= w_bit_nxt;
      end
   end

   // Next-state, counter update and output decode; abort beats the end-of-frame wrap.
   always_comb begin
      w_state_nxt = r_state;
      w_div_nxt   = r_div_cnt;
      w_bit_nxt   = r_bit_cnt;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      in_ready    = 1'b0;
      frame       = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      serial_out  = IDLE_LVL;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_load      = 1'b1;
               w_div_nxt   = {DIV_W{1'b0}};
               w_bit_nxt   = {BIT_W{1'b0}};
               w_state_nxt = ST_SHIFT;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            frame      = 1'b1;
            busy       = 1'b1;
            serial_out = w_head;
            if (abort) begin
               w_state_nxt = ST_IDLE;
            end else if (r_div_cnt == DIV_LAST) begin
               w_div_nxt = {DIV_W{1'b0}};
               w_shift   = 1'b1;
               w_bit_nxt = r_bit_cnt + BIT_W'(1);
               if (r_bit_cnt == BIT_LAST) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_state_nxt = ST_SHIFT;
               end
            end else begin
               w_div_nxt = r_div_cnt + DIV_W'(1);
            end
         end
         ST_DONE: begin
            done        = 1'b1;
            busy        = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Directed bench: MSB-first and LSB-first instances at DIV=4 share stimulus,
// a third instance runs DIV=1; every check goes through chk().
module tb_piso_tx_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       vld_a, abort_a, vld_b;
   logic [7:0] pd_a, pd_b;
   logic       rdy_m, so_m, fr_m, bz_m, dn_m;
   logic       rdy_l, so_l, fr_l, bz_l, dn_l;
   logic       rdy_b, so_b, fr_b, bz_b, dn_b;
   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   int         done_cyc = 0;

   // Expected {frame, serial_out, in_ready, done, busy} outside SHIFT.
   localparam logic [4:0] E_IDLE = 5'b01100;
   localparam logic [4:0] E_DONE = 5'b01011;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   piso_tx_ctrl #(.N(8), .DIV(4), .MSB_FIRST(1'b1), .IDLE_LVL(1'b1)) u_msb (
      .clk(clk), .reset(rst_n), .in_valid(vld_a), .in_ready(rdy_m), .parallel_in(pd_a),
      .abort(abort_a), .serial_out(so_m), .frame(fr_m), .busy(bz_m), .done(dn_m));

   piso_tx_ctrl #(.N(8), .DIV(4), .MSB_FIRST(1'b0), .IDLE_LVL(1'b1)) u_lsb (
      .clk(clk), .reset(rst_n), .in_valid(vld_a), .in_ready(rdy_l), .parallel_in(pd_a),
      .abort(abort_a), .serial_out(so_l), .frame(fr_l), .busy(bz_l), .done(dn_l));

   piso_tx_ctrl #(.N(8), .DIV(1), .MSB_FIRST(1'b1), .IDLE_LVL(1'b1)) u_div1 (
      .clk(clk), .reset(rst_n), .in_valid(vld_b), .in_ready(rdy_b), .parallel_in(pd_b),
      .abort(1'b0), .serial_out(so_b), .frame(fr_b), .busy(bz_b), .done(dn_b));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   function automatic logic [9:0] obs_a();
      return {fr_m, so_m, rdy_m, dn_m, bz_m, fr_l, so_l, rdy_l, dn_l, bz_l};
   endfunction

   // Present a word on instance A/B pair; returns #1 after the accept edge.
   task automatic send_a(input logic [7:0] w, input logic keep);
      @(negedge clk);
      vld_a = 1'b1;
      pd_a  = w;
      chk("a_ready_before", {30'd0, rdy_m, rdy_l}, 32'd3);
      @(posedge clk);
      #1;
      if (!keep) vld_a = 1'b0;
   endtask

   // sm/sl list the expected line bits, first-sent bit in position 7.
   task automatic watch_a(input logic [7:0] sm, input logic [7:0] sl, input int stop);
      int idx;
      for (int c = 1; c <= stop && c <= 32; c++) begin
         @(negedge clk);
         idx = 7 - (c - 1) / 4;
         chk($sformatf("a_shift_c%0d", c), {22'd0, obs_a()},
             {22'd0, 1'b1, sm[idx], 3'b001, 1'b1, sl[idx], 3'b001});
      end
      if (stop >= 33) begin
         @(negedge clk);
         chk("a_done_c33", {22'd0, obs_a()}, {22'd0, E_DONE, E_DONE});
         @(negedge clk);
         chk("a_idle_c34", {22'd0, obs_a()}, {22'd0, E_IDLE, E_IDLE});
      end
   endtask

   task automatic watch_b(input logic [7:0] s);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         chk($sformatf("b_shift_c%0d", c), {27'd0, fr_b, so_b, rdy_b, dn_b, bz_b},
             {27'd0, 1'b1, s[8 - c], 3'b001});
      end
      @(negedge clk);
      done_cyc = cyc;
      chk("b_done", {27'd0, fr_b, so_b, rdy_b, dn_b, bz_b}, {27'd0, E_DONE});
      @(negedge clk);
      chk("b_idle", {27'd0, fr_b, so_b, rdy_b, dn_b, bz_b}, {27'd0, E_IDLE});
   endtask

   initial begin
      int d1;
      logic saw_done;
      rst_n   = 1'b0;
      vld_a   = 1'b0;
      vld_b   = 1'b0;
      abort_a = 1'b0;
      pd_a    = 8'h00;
      pd_b    = 8'h00;
      #3;
      chk("reset_a", {22'd0, obs_a()}, {22'd0, E_IDLE, E_IDLE});
      chk("reset_b", {27'd0, fr_b, so_b, rdy_b, dn_b, bz_b}, {27'd0, E_IDLE});
      #9;
      rst_n = 1'b1;

      // A5 both directions, then 01.
      send_a(8'hA5, 1'b0);
      watch_a(8'b10100101, 8'b10100101, 34);
      send_a(8'h01, 1'b0);
      watch_a(8'b00000001, 8'b10000000, 34);

      // Valid held: F0 then 0F, second accept lands in the IDLE cycle k+34.
      send_a(8'hF0, 1'b1);
      pd_a = 8'h0F;
      watch_a(8'b11110000, 8'b00001111, 34);
      @(posedge clk);
      #1;
      vld_a = 1'b0;
      watch_a(8'b00001111, 8'b11110000, 34);

      // Abort during bit 3.
      send_a(8'hA5, 1'b0);
      watch_a(8'b10100101, 8'b10100101, 13);
      abort_a = 1'b1;
      @(posedge clk);
      #1;
      abort_a = 1'b0;
      @(negedge clk);
      chk("abort_idle", {22'd0, obs_a()}, {22'd0, E_IDLE, E_IDLE});
      saw_done = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         saw_done = saw_done | dn_m | dn_l | fr_m | fr_l;
      end
      chk("abort_no_done", {31'd0, saw_done}, 32'd0);

      // Abort coinciding with accept in IDLE: accept wins.
      @(negedge clk);
      vld_a   = 1'b1;
      pd_a    = 8'h5A;
      abort_a = 1'b1;
      @(posedge clk);
      #1;
      vld_a   = 1'b0;
      abort_a = 1'b0;
      watch_a(8'b01011010, 8'b01011010, 34);

      // Asynchronous reset mid-frame, then a clean 3C frame.
      send_a(8'hA5, 1'b0);
      watch_a(8'b10100101, 8'b10100101, 10);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset", {22'd0, obs_a()}, {22'd0, E_IDLE, E_IDLE});
      #4;
      rst_n = 1'b1;
      send_a(8'h3C, 1'b0);
      watch_a(8'b00111100, 8'b00111100, 34);

      // DIV=1 back-to-back FF then 00.
      @(negedge clk);
      vld_b = 1'b1;
      pd_b  = 8'hFF;
      @(posedge clk);
      #1;
      pd_b = 8'h00;
      watch_b(8'hFF);
      d1 = done_cyc;
      @(posedge clk);
      #1;
      vld_b = 1'b0;
      watch_b(8'h00);
      chk("b_done_gap", done_cyc - d1, 32'd10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
